// File: rtl/led_pwm_driver_if.sv
// Colour/enable inputs and PWM/status outputs of the LED PWM driver.
// The master modport is the colour source, the slave modport is the driver.
interface led_pwm_driver_if;
    logic [2:0] colour;
    logic       enable;
    logic       red;
    logic       green;
    logic       blue;
    logic       busy;
    logic       pwm_wrap;

    modport master (
        output colour,
        output enable,
        input  red,
        input  green,
        input  blue,
        input  busy,
        input  pwm_wrap
    );

    modport slave (
        input  colour,
        input  enable,
        output red,
        output green,
        output blue,
        output busy,
        output pwm_wrap
    );
endinterface

// File: rtl/led_pwm_driver.sv
// Three-channel LED PWM driver that fades each duty toward a colour-decoded target once per fade tick.
// Outputs are registered one cycle behind the counter; there is no backpressure, colour is sampled every clk.
module led_pwm_driver #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 16,
    parameter int FADE_DIV = 1
) (
    input  logic            clk,
    input  logic            rst,
    led_pwm_driver_if.slave led
);
    localparam int                  DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] FULL     = '1;
    localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(STEP);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_FADE,
        S_STEADY
    } state_t;

    state_t                     state;
    logic [2:0]                 colour_q;
    logic [PWM_BITS-1:0]        cnt;
    logic [DIV_W-1:0]           div;
    logic [2:0][PWM_BITS-1:0]   duty;
    logic [2:0][PWM_BITS-1:0]   tgt;
    logic [2:0][PWM_BITS-1:0]   duty_nxt;
    logic [2:0]                 rgb_q;
    logic                       tick;

    // Compares run one bit wider than the duty so d+STEP / t+STEP never wrap.
    function automatic logic [PWM_BITS-1:0] fade_step(input logic [PWM_BITS-1:0] d,
                                                      input logic [PWM_BITS-1:0] t);
        logic [PWM_BITS:0] dw;
        logic [PWM_BITS:0] tw;
        dw = {1'b0, d};
        tw = {1'b0, t};
        if (dw < tw) begin
            if (dw + STEP_W >= tw) return t;
            return d + PWM_BITS'(STEP);
        end
        if (dw > tw) begin
            if (dw <= tw + STEP_W) return t;
            return d - PWM_BITS'(STEP);
        end
        return d;
    endfunction

    // Channel index 2 = red, 1 = green, 0 = blue.
    always_comb begin
        tgt = '0;
        case (colour_q)
            3'b001: tgt[2] = FULL;
            3'b010: tgt[1] = FULL;
            3'b011: tgt[0] = FULL;
            3'b100: begin tgt[2] = FULL; tgt[1] = FULL; end
            3'b101: begin tgt[1] = FULL; tgt[0] = FULL; end
            3'b110: begin tgt[2] = FULL; tgt[0] = FULL; end
            default: tgt = '0;
        endcase
    end

    always_comb begin
        duty_nxt = duty;
        for (int i = 0; i < 3; i++) begin
            duty_nxt[i] = fade_step(duty[i], tgt[i]);
        end
    end

    assign led.pwm_wrap = led.enable && (cnt == FULL);
    assign tick         = led.pwm_wrap && (div == DIV_LAST);
    assign led.busy     = led.enable && (duty != tgt);
    assign led.red      = rgb_q[2];
    assign led.green    = rgb_q[1];
    assign led.blue     = rgb_q[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_OFF;
            colour_q <= '0;
            cnt      <= '0;
            div      <= '0;
            duty     <= '0;
            rgb_q    <= '0;
        end else begin
            colour_q <= led.colour;
            if (!led.enable) begin
                state <= S_OFF;
                cnt   <= '0;
                div   <= '0;
                duty  <= '0;
                rgb_q <= '0;
            end else begin
                cnt <= cnt + PWM_BITS'(1);
                for (int i = 0; i < 3; i++) begin
                    rgb_q[i] <= (cnt < duty[i]);
                end
                // Duties only move on the wrap edge so a period never sees two values.
                if (led.pwm_wrap) begin
                    if (tick) begin
                        div  <= '0;
                        duty <= duty_nxt;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                case (state)
                    S_OFF:    state <= S_FADE;
                    S_FADE:   if (tick && (duty_nxt == tgt)) state <= S_STEADY;
                    S_STEADY: if (duty != tgt) state <= S_FADE;
                    default:  state <= S_OFF;
                endcase
            end
        end
    end
endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter PWM_BITS, default 8, SHALL set the PWM counter and duty register width.
REQ-002 Parameter STEP, default 16, SHALL set the duty increment/decrement per fade step (1..2^PWM_BITS-1).
REQ-003 Parameter FADE_DIV, default 1, SHALL set the number of PWM periods per fade step (>=1).
REQ-004 clk  input  1  SHALL be the single rising-edge clock.
REQ-005 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 colour  input  3  SHALL be the colour code from the LED stage, sampled every clk.
REQ-007 enable  input  1  SHALL gate all outputs; low means lights off.
REQ-008 red, green, blue  output  1 each  SHALL be the PWM drive for each LED channel.
REQ-009 busy  output  1  SHALL be high while any channel duty differs from its target.
REQ-010 pwm_wrap  output  1  SHALL pulse for one cycle when the PWM counter equals 2^PWM_BITS-1.

Function
REQ-011 Colour code SHALL be registered once (colour_q) before decode; no other input synchronisation.
REQ-012 Target decode (R,G,B), with F = 2^PWM_BITS-1, SHALL be:
- 001 = (F,0,0); 010 = (0,F,0); 011 = (0,0,F)
- 100 = (F,F,0); 101 = (0,F,F); 110 = (F,0,F)
- 000 and 111 = (0,0,0)
REQ-013 PWM counter SHALL free-run 0..2^PWM_BITS-1 and wrap to 0 while enable=1.
REQ-014 Channel output SHALL be high iff enable=1 and counter < duty, registered: duty 0 means never high; duty F means high F of 2^PWM_BITS cycles.
REQ-015 Duty registers SHALL change only on the cycle pwm_wrap is high, so no mid-period glitches occur.
REQ-016 A fade-step tick SHALL occur on every FADE_DIV-th pwm_wrap, counted by a period divider reset to 0 on each tick.
REQ-017 On each tick, per channel:
- duty < target: duty += STEP, saturating at target.
- duty > target: duty -= STEP, saturating at target.
- Equal: hold.
- Saturation compare SHALL be done at PWM_BITS+1 width, so no wrap-around occurs.
REQ-018 FSM states and transitions SHALL be:
- OFF: enable=0 -> FADE when enable=1.
- FADE: busy=1; -> STEADY when all duties equal targets after a tick.
- STEADY: -> FADE when a target changes.
- Any state -> OFF on enable=0.
REQ-019 A colour change mid-fade SHALL retarget immediately; fading continues from the current duty values with no restart.
REQ-020 On enable=0, the next cycle SHALL force duties, counter and divider to 0 and all PWM outputs low; pwm_wrap SHALL stay 0 in OFF.
REQ-021 busy SHALL be combinational from (duty != target) for any channel, gated by enable.

Reset
REQ-022 While rst=0, the following SHALL be 0 asynchronously: counter, divider, duties, colour_q, red, green, blue, busy and pwm_wrap; the FSM SHALL be in OFF.
REQ-023 Release of rst SHALL take effect on the next clk edge, with the first counter increment on the first clk edge after release.
REQ-024 Reset asserted mid-fade SHALL discard all fade progress; after release, fading restarts from duty 0.

Verification (PWM_BITS=8, STEP=16, FADE_DIV=1)
REQ-025 Reset: rst=0 with clk running -> red, green, blue, busy and pwm_wrap are 0 on every cycle, and stay 0 until rst rises.
REQ-026 Fade up: enable=1, colour=001 -> red duty goes 0,16,...,240,255 (16 ticks, 4096 cycles); busy falls at the last tick; green and blue stay 0.
REQ-027 Steady duty: colour=100 settled -> red and green each high exactly 255 of every 256 cycles; blue never high; pwm_wrap once per 256 cycles.
REQ-028 Retarget: colour 001 -> 010 when red duty=128 -> red steps 112,96,...,0 while green steps 16,...,255 on the same ticks; no period contains a duty change mid-period.
REQ-029 Off codes and enable: colour=111 from steady 011 -> blue fades 255->0 in 16 ticks. enable=0 mid-fade -> all outputs low the next cycle; enable=1 restarts from 0.
REQ-030 Async reset mid-fade: rst pulsed low between clk edges at duty=64 -> outputs 0 immediately; after release, duty restarts from 0 and busy=1 once enable=1.
